final_link_serdes: RTL
======================

FINAL_LINK_SERDES -- requirements
Module: final_link_serdes

Interface
REQ-001 The block SHALL have parameter CODE_DISTANCE_X, default 5, the X code distance.
REQ-002 The block SHALL have parameter CODE_DISTANCE_Z, default 4, the Z code distance.
REQ-003 The block SHALL have parameter LINK_WIDTH, default 8, the physical flit width.
REQ-004 The block SHALL have parameter CREDITS, default 16, the far-end receive buffer depth in words.
REQ-005 The block SHALL derive its widths as follows: MR = max(X,Z); ADDRESS_WIDTH = 3*clog2(MR); MASTER_FIFO_WIDTH = 2*ADDRESS_WIDTH+2; FIFO_COUNT = MR*Z; FINAL_FIFO_WIDTH (FW) = MASTER_FIFO_WIDTH+clog2(FIFO_COUNT+1); FLITS = ceil(FW/LINK_WIDTH). With the defaults, FW=25 and FLITS=4.
REQ-006 The block SHALL have these ports, clock and reset first, each as name / direction / width / meaning:
- clk / in / 1 / single clock
- reset_n / in / 1 / asynchronous, active-low reset
- tx_data / in / FW / tagged word from the final out FIFO
- tx_valid / in / 1 / tx_data valid
- tx_ready / out / 1 / word accepted this cycle
- link_tx_data / out / LINK_WIDTH / outgoing flit
- link_tx_valid / out / 1 / flit valid
- link_tx_sof / out / 1 / first flit of word
- link_credit_in / in / 1 / one-cycle pulse, one far-end word freed
- link_rx_data / in / LINK_WIDTH / incoming flit
- link_rx_valid / in / 1 / incoming flit valid
- link_rx_sof / in / 1 / incoming first flit
- link_credit_out / out / 1 / one-cycle pulse, one local word freed
- rx_data / out / FW / reassembled word toward the final in FIFO
- rx_valid / out / 1 / rx_data valid
- rx_ready / in / 1 / consumer takes rx_data
- frame_error / out / 1 / sticky framing error
- overflow_error / out / 1 / sticky receive overflow
- credit_error / out / 1 / sticky credit over-return
- link_busy / out / 1 / messages in flight

Function
REQ-007 The TX path SHALL implement an FSM with states IDLE and SEND, a flit counter, and a credit counter of width clog2(CREDITS+1).
REQ-008 tx_ready SHALL equal (state==IDLE && credit!=0 && reset_n); a word is accepted when tx_valid && tx_ready.
REQ-009 On acceptance the TX path SHALL latch tx_data, decrement credit and enter SEND.
REQ-010 In SEND the TX path SHALL drive link_tx_valid=1 for exactly FLITS consecutive cycles, starting the cycle after acceptance.
REQ-011 In SEND, flit k SHALL be bits [k*LINK_WIDTH +: LINK_WIDTH] of the latched word, LSB flit first, with the final flit zero-padded above FW.
REQ-012 link_tx_sof SHALL be 1 only on flit 0; the link has no backpressure.
REQ-013 After the last flit the TX path SHALL return to IDLE, giving a throughput of one word per FLITS+1 cycles; tx_ready is never asserted in SEND.
REQ-014 When link_tx_valid=0, link_tx_data and link_tx_sof SHALL be 0.
REQ-015 Credit counter updates SHALL be: link_credit_in alone increments; acceptance alone decrements; both in the same cycle leave the counter unchanged.
REQ-016 A credit_in arriving while credit==CREDITS (and with no simultaneous acceptance) SHALL leave the counter saturated and set credit_error.
REQ-017 The RX path SHALL assemble flits into a word using a flit index; link_rx_sof with link_rx_valid loads flit 0 and sets the index to 1.
REQ-018 In the RX path, a valid non-sof flit while index==0 SHALL be discarded and set frame_error.
REQ-019 In the RX path, sof while index!=0 SHALL discard the partial word, set frame_error, and treat the current flit as flit 0 of a new word.
REQ-020 In the RX path, completion of flit FLITS-1 SHALL push the assembled low FW bits into an internal first-word-fall-through buffer of depth CREDITS and reset the index to 0.
REQ-021 If the RX buffer is full at a push, the word SHALL be dropped, overflow_error set, and buffer contents left unchanged.
REQ-022 rx_valid SHALL equal buffer not empty; rx_data SHALL be the buffer head; a pop occurs when rx_valid && rx_ready.
REQ-023 A push and a pop in the same cycle SHALL both take effect, including when the buffer is full (the pop frees the slot first).
REQ-024 link_credit_out SHALL be a registered pulse, high the cycle after each pop.
REQ-025 Error flags SHALL be sticky until reset.
REQ-026 link_busy SHALL be a registered OR of: state==SEND, credit!=CREDITS, RX index!=0, RX buffer not empty.

Reset
REQ-027 While reset_n=0, asynchronously: FSM=IDLE, credit=CREDITS, flit counter and RX index=0, RX buffer empty; all outputs 0 (tx_ready=0, link_tx_*=0, rx_valid=0, rx_data=0, link_credit_out=0, all error flags=0, link_busy=0).
REQ-028 Reset asserted mid-word SHALL abandon the word; the block does not resume it after reset release.
REQ-029 Reset release SHALL be synchronized internally, so that the first acceptance can occur no earlier than the second rising clk edge after release.

Verification
REQ-030 Single word: tx_data=25'h1ABCDEF -> flits 0xEF(sof), 0xCD, 0xAB, 0x01 on cycles 1-4; credit 16->15; link_busy=1.
REQ-031 Credit exhaustion: 16 words sent with no credit_in -> tx_ready stays 0 on the 17th; one credit_in pulse -> 17th word is accepted the next cycle.
REQ-032 RX reassembly: flits 0x44(sof), 0x33, 0x22, 0x01 -> rx_data=25'h1223344, rx_valid=1; holding rx_ready=0 keeps the word stable; a pop -> link_credit_out pulse one cycle later.
REQ-033 Framing: sof, 0x11, then sof=1 on the third flit -> frame_error=1, first partial discarded, new word assembled from the second sof.
REQ-034 Overflow: 17 complete words received with no pops -> overflow_error=1, 17th dropped, first 16 popped intact in order.
REQ-035 Reset mid-SEND: reset_n=0 at flit 2 -> link_tx_valid=0 immediately, credit=16, no flits after release until a new acceptance.

Source files
------------

// File: rtl/final_link_serdes.sv
// final_link_serdes: credit-flow flit serializer / deserializer for tagged FIFO words
module final_link_serdes #(
    parameter int CODE_DISTANCE_X = 5,
    parameter int CODE_DISTANCE_Z = 4,
    parameter int LINK_WIDTH      = 8,
    parameter int CREDITS         = 16,
    localparam int MR    = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int AW    = 3 * $clog2(MR),
    localparam int MFW   = 2 * AW + 2,
    localparam int FC    = MR * CODE_DISTANCE_Z,
    localparam int FW    = MFW + $clog2(FC + 1),
    localparam int FLITS = (FW + LINK_WIDTH - 1) / LINK_WIDTH,
    localparam int CW    = $clog2(CREDITS + 1),
    localparam int IW    = (FLITS > 1) ? $clog2(FLITS) : 1,
    localparam int PW    = (CREDITS > 1) ? $clog2(CREDITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [FW-1:0]         tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [LINK_WIDTH-1:0] link_tx_data,
    output logic                  link_tx_valid,
    output logic                  link_tx_sof,
    input  logic                  link_credit_in,
    input  logic [LINK_WIDTH-1:0] link_rx_data,
    input  logic                  link_rx_valid,
    input  logic                  link_rx_sof,
    output logic                  link_credit_out,
    output logic [FW-1:0]         rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_error,
    output logic                  overflow_error,
    output logic                  credit_error,
    output logic                  link_busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           flit_q, flit_d;
    logic [CW-1:0]           credit_q, credit_d;
    logic [FLITS*LINK_WIDTH-1:0] word_q, word_d;
    logic                    sync1_q, sync2_q;
    logic                    accept;

    logic [IW-1:0]           idx_q, idx_d, widx;
    logic [FLITS*LINK_WIDTH-1:0] asm_q, asm_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]           count_q, count_d;
    logic [FW-1:0]           mem_q [CREDITS];
    logic                    take, done, full, push, pop;
    logic                    ferr_q, ferr_d, oerr_q, oerr_d, cerr_q, cerr_d;
    logic                    cout_q, busy_q, busy_d;

    assign tx_ready        = state_q == IDLE && credit_q != '0 && reset_n && sync2_q;
    assign accept          = tx_valid && tx_ready;
    assign link_tx_valid   = state_q == SEND;
    assign link_tx_data    = link_tx_valid ? word_q[flit_q*LINK_WIDTH +: LINK_WIDTH] : '0;
    assign link_tx_sof     = link_tx_valid && flit_q == '0;
    assign rx_valid        = count_q != '0;
    assign rx_data         = rx_valid ? mem_q[rd_q] : '0;
    assign pop             = rx_valid && rx_ready;
    assign full            = count_q == CW'(CREDITS);
    assign link_credit_out = cout_q;
    assign frame_error     = ferr_q;
    assign overflow_error  = oerr_q;
    assign credit_error    = cerr_q;
    assign link_busy       = busy_q;

    // TX sequencing: latch on accept, then walk FLITS flits LSB first
    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        word_d  = word_q;
        if (accept) begin
            state_d = SEND;
            flit_d  = '0;
            word_d  = '0;
            word_d[FW-1:0] = tx_data;
        end else if (state_q == SEND) begin
            flit_d = flit_q + 1'b1;
            if (flit_q == IW'(FLITS - 1)) begin
                state_d = IDLE;
                flit_d  = '0;
            end
        end
    end

    // Credit accounting; a return while already full saturates and flags
    always_comb begin
        credit_d = credit_q;
        cerr_d   = cerr_q;
        if (accept && !link_credit_in)
            credit_d = credit_q - 1'b1;
        else if (!accept && link_credit_in) begin
            if (credit_q == CW'(CREDITS))
                cerr_d = 1'b1;
            else
                credit_d = credit_q + 1'b1;
        end
    end

    // RX reassembly, framing checks and receive buffer bookkeeping
    always_comb begin
        take    = link_rx_valid && (link_rx_sof || idx_q != '0);
        widx    = link_rx_sof ? '0 : idx_q;
        done    = take && widx == IW'(FLITS - 1);
        asm_d   = asm_q;
        if (take)
            asm_d[widx*LINK_WIDTH +: LINK_WIDTH] = link_rx_data;
        idx_d   = !take ? idx_q : done ? '0 : widx + 1'b1;
        ferr_d  = ferr_q || (link_rx_valid && (link_rx_sof ? idx_q != '0 : idx_q == '0));
        push    = done && (!full || pop);
        oerr_d  = oerr_q || (done && full && !pop);
        count_d = count_q + CW'(push) - CW'(pop);
        wr_d    = !push ? wr_q : (wr_q == PW'(CREDITS - 1)) ? '0 : wr_q + 1'b1;
        rd_d    = !pop  ? rd_q : (rd_q == PW'(CREDITS - 1)) ? '0 : rd_q + 1'b1;
        busy_d  = state_q == SEND || credit_q != CW'(CREDITS) || idx_q != '0 || count_q != '0;
    end

    // All control state, cleared asynchronously; reset release is resynchronized
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            flit_q   <= '0;
            credit_q <= CW'(CREDITS);
            word_q   <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
            cerr_q   <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= 1'b1;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            flit_q   <= flit_d;
            credit_q <= credit_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
            cerr_q   <= cerr_d;
            cout_q   <= pop;
            busy_q   <= busy_d;
        end
    end

    // Receive buffer storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= asm_d[FW-1:0];
    end

endmodule
